// File: rtl/multiport_register_file.sv
// Register file with NUM_READ combinational read ports, one write port, optional
// hard-wired zero register, optional write-to-read bypass and a pending-write scoreboard.
module multiport_register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_EN    = 1,
    parameter int ZERO_REG   = 31,
    parameter int BYPASS_EN  = 1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] RA,
    output logic [NUM_READ*DATA_WIDTH-1:0] BusR,
    output logic [NUM_READ-1:0]            Ready,
    input  logic                           RegWr,
    input  logic [ADDR_WIDTH-1:0]          RW,
    input  logic [DATA_WIDTH-1:0]          BusW,
    input  logic                           Lock,
    input  logic [ADDR_WIDTH-1:0]          LockReg,
    output logic [ADDR_WIDTH:0]            PendCount,
    output logic                           PendAny
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
    localparam bit                    ZERO_ON   = (ZERO_EN != 0);
    localparam bit                    BYPASS_ON = (BYPASS_EN != 0);

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return ZERO_ON && (a == ZERO_ADDR);
    endfunction

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_pend;
    logic [ADDR_WIDTH:0]   r_pend_cnt;

    logic w_wr_en;
    logic w_lk_en;
    logic w_inc;
    logic w_dec;

    // The zero register never stores data and never becomes pending.
    assign w_wr_en = RegWr && !is_zero(RW);
    assign w_lk_en = Lock && !is_zero(LockReg);

    // A same-register lock supersedes the completing write, so that write must not decrement.
    assign w_inc = w_lk_en && !r_pend[LockReg];
    assign w_dec = w_wr_en && r_pend[RW] && !(w_lk_en && (LockReg == RW));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_regs[r] <= '0;
            end
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[RW] <= BusW;
                r_pend[RW] <= 1'b0;
            end
            // Issued after the clear so a same-register lock wins.
            if (w_lk_en) begin
                r_pend[LockReg] <= 1'b1;
            end
            case ({w_inc, w_dec})
                2'b10:   r_pend_cnt <= r_pend_cnt + 1'b1;
                2'b01:   r_pend_cnt <= r_pend_cnt - 1'b1;
                default: r_pend_cnt <= r_pend_cnt;
            endcase
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] w_ra;
        logic                  w_hit;
        BusR  = '0;
        Ready = '0;
        w_ra  = '0;
        w_hit = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            w_ra  = RA[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_hit = BYPASS_ON && RegWr && (RW == w_ra);
            if (is_zero(w_ra)) begin
                BusR[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                Ready[i]                         = 1'b1;
            end else begin
                BusR[i*DATA_WIDTH +: DATA_WIDTH] = w_hit ? BusW : r_regs[w_ra];
                Ready[i]                         = !r_pend[w_ra] || w_hit;
            end
        end
    end

    assign PendCount = r_pend_cnt;
    assign PendAny   = (r_pend_cnt != '0);

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// array-based reference model; a second instance covers the no-bypass variant.
module tb_multiport_register_file;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 2;

    logic           Clk;
    logic           Reset;
    logic [NR*AW-1:0] RA;
    logic [NR*DW-1:0] BusR, BusR_nb;
    logic [NR-1:0]  Ready, Ready_nb;
    logic           RegWr;
    logic [AW-1:0]  RW;
    logic [DW-1:0]  BusW;
    logic           Lock;
    logic [AW-1:0]  LockReg;
    logic [AW:0]    PendCount, PendCount_nb;
    logic           PendAny, PendAny_nb;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] m_regs [32];
    bit            m_pend [32];

    multiport_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
                              .ZERO_EN(1), .ZERO_REG(31), .BYPASS_EN(1)) u_dut (
        .Clk(Clk), .Reset(Reset), .RA(RA), .BusR(BusR), .Ready(Ready),
        .RegWr(RegWr), .RW(RW), .BusW(BusW), .Lock(Lock), .LockReg(LockReg),
        .PendCount(PendCount), .PendAny(PendAny));

    multiport_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
                              .ZERO_EN(1), .ZERO_REG(31), .BYPASS_EN(0)) u_nb (
        .Clk(Clk), .Reset(Reset), .RA(RA), .BusR(BusR_nb), .Ready(Ready_nb),
        .RegWr(RegWr), .RW(RW), .BusW(BusW), .Lock(Lock), .LockReg(LockReg),
        .PendCount(PendCount_nb), .PendAny(PendAny_nb));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < 32; r++) c += m_pend[r];
        return c;
    endfunction

    function automatic logic [DW-1:0] exp_bus(input logic [AW-1:0] a, input bit byp);
        if (a == 31) return '0;
        if (byp && RegWr && RW == a) return BusW;
        return m_regs[a];
    endfunction

    function automatic logic exp_rdy(input logic [AW-1:0] a, input bit byp);
        if (a == 31) return 1'b1;
        if (!m_pend[a]) return 1'b1;
        return byp && RegWr && (RW == a);
    endfunction

    task automatic model_step();
        if (Reset) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 0;
            end
        end else begin
            if (RegWr && RW != 31) begin
                m_regs[RW] = BusW;
                m_pend[RW] = 0;
            end
            if (Lock && LockReg != 31) m_pend[LockReg] = 1;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
    endtask

    task automatic idle();
        Reset = 0; RegWr = 0; Lock = 0; RW = '0; LockReg = '0; BusW = '0;
    endtask

    task automatic test_reset();
        Reset = 1; RegWr = 1; RW = 5'd3; BusW = 64'hAA;
        RA = {5'd5, 5'd0};
        tick();
        idle();
        #1;
        n_checks++; if (BusR !== '0) begin n_fail++; $display("FAIL reset_busr got=%h want=0", BusR); end
        n_checks++; if (Ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready got=%b want=11", Ready); end
        n_checks++; if (PendCount !== 6'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", PendCount); end
        n_checks++; if (PendAny !== 1'b0) begin n_fail++; $display("FAIL reset_any got=%b want=0", PendAny); end
        RA = {5'd5, 5'd3};
        #1;
        n_checks++; if (BusR[DW-1:0] !== 64'h0) begin n_fail++; $display("FAIL reset_drops_write got=%h want=0", BusR[DW-1:0]); end
    endtask

    task automatic test_write_bypass();
        RegWr = 1; RW = 5'd7; BusW = 64'hDEAD_BEEF; RA = {5'd0, 5'd7};
        #1;
        n_checks++; if (BusR[DW-1:0] !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_same_cycle got=%h want=deadbeef", BusR[DW-1:0]); end
        n_checks++; if (BusR_nb[DW-1:0] !== 64'h0) begin n_fail++; $display("FAIL nobypass_same_cycle got=%h want=0", BusR_nb[DW-1:0]); end
        tick();
        idle();
        #1;
        n_checks++; if (BusR[DW-1:0] !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL write_stored got=%h want=deadbeef", BusR[DW-1:0]); end
        n_checks++; if (BusR_nb[DW-1:0] !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL nb_write_stored got=%h want=deadbeef", BusR_nb[DW-1:0]); end
    endtask

    task automatic test_zero_reg();
        RegWr = 1; RW = 5'd31; BusW = 64'h1234; RA = {5'd31, 5'd31};
        #1;
        n_checks++; if (BusR[DW-1:0] !== 64'h0) begin n_fail++; $display("FAIL zero_no_bypass got=%h want=0", BusR[DW-1:0]); end
        tick();
        idle();
        Lock = 1; LockReg = 5'd31;
        tick();
        idle();
        #1;
        n_checks++; if (BusR !== '0) begin n_fail++; $display("FAIL zero_read got=%h want=0", BusR); end
        n_checks++; if (Ready !== 2'b11) begin n_fail++; $display("FAIL zero_ready got=%b want=11", Ready); end
        n_checks++; if (PendCount !== 6'd0) begin n_fail++; $display("FAIL zero_count got=%0d want=0", PendCount); end
    endtask

    task automatic test_scoreboard();
        Lock = 1; LockReg = 5'd4; tick();
        LockReg = 5'd9; tick();
        idle();
        RA = {5'd9, 5'd4};
        #1;
        n_checks++; if (PendCount !== 6'd2) begin n_fail++; $display("FAIL sb_count2 got=%0d want=2", PendCount); end
        n_checks++; if (PendAny !== 1'b1) begin n_fail++; $display("FAIL sb_any got=%b want=1", PendAny); end
        n_checks++; if (Ready !== 2'b00) begin n_fail++; $display("FAIL sb_ready_locked got=%b want=00", Ready); end
        RegWr = 1; RW = 5'd4; BusW = 64'h44;
        #1;
        n_checks++; if (Ready[0] !== 1'b1) begin n_fail++; $display("FAIL sb_ready_bypass got=%b want=1", Ready[0]); end
        n_checks++; if (Ready_nb[0] !== 1'b0) begin n_fail++; $display("FAIL sb_ready_nobypass got=%b want=0", Ready_nb[0]); end
        tick();
        idle();
        #1;
        n_checks++; if (PendCount !== 6'd1) begin n_fail++; $display("FAIL sb_count1 got=%0d want=1", PendCount); end
        n_checks++; if (Ready !== 2'b01) begin n_fail++; $display("FAIL sb_ready_after got=%b want=01", Ready); end
    endtask

    task automatic test_simultaneous();
        // r9 pending from the previous scenario; add r6
        Lock = 1; LockReg = 5'd6; tick();
        RegWr = 1; RW = 5'd6; BusW = 64'h66; Lock = 1; LockReg = 5'd6; tick();
        idle();
        RA = {5'd9, 5'd6};
        #1;
        n_checks++; if (PendCount !== 6'd2) begin n_fail++; $display("FAIL sim_same_count got=%0d want=2", PendCount); end
        n_checks++; if (Ready[0] !== 1'b0) begin n_fail++; $display("FAIL sim_same_p6 got=%b want=0", Ready[0]); end
        Lock = 1; LockReg = 5'd2; RegWr = 1; RW = 5'd9; BusW = 64'h99; tick();
        idle();
        RA = {5'd9, 5'd2};
        #1;
        n_checks++; if (PendCount !== 6'd2) begin n_fail++; $display("FAIL sim_diff_count got=%0d want=2", PendCount); end
        n_checks++; if (Ready !== 2'b10) begin n_fail++; $display("FAIL sim_diff_ready got=%b want=10", Ready); end
        n_checks++; if (BusR[2*DW-1:DW] !== 64'h99) begin n_fail++; $display("FAIL sim_diff_data got=%h want=99", BusR[2*DW-1:DW]); end
    endtask

    task automatic test_random(input int cycles);
        logic [AW-1:0] a;
        for (int c = 0; c < cycles; c++) begin
            Reset   = ($urandom_range(0, 59) == 0);
            RegWr   = ($urandom_range(0, 1) == 1);
            Lock    = ($urandom_range(0, 9) < 4);
            RW      = AW'($urandom_range(0, 31));
            LockReg = ($urandom_range(0, 4) == 0) ? RW : AW'($urandom_range(0, 31));
            BusW    = {$urandom, $urandom};
            for (int p = 0; p < NR; p++) begin
                RA[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? RW : AW'($urandom_range(0, 31));
            end
            #1;
            for (int p = 0; p < NR; p++) begin
                a = RA[p*AW +: AW];
                n_checks++; if (BusR[p*DW +: DW] !== exp_bus(a, 1)) begin n_fail++; $display("FAIL rnd_busr c=%0d p=%0d got=%h want=%h", c, p, BusR[p*DW +: DW], exp_bus(a, 1)); end
                n_checks++; if (BusR_nb[p*DW +: DW] !== exp_bus(a, 0)) begin n_fail++; $display("FAIL rnd_busr_nb c=%0d p=%0d got=%h want=%h", c, p, BusR_nb[p*DW +: DW], exp_bus(a, 0)); end
                n_checks++; if (Ready[p] !== exp_rdy(a, 1)) begin n_fail++; $display("FAIL rnd_ready c=%0d p=%0d got=%b want=%b", c, p, Ready[p], exp_rdy(a, 1)); end
                n_checks++; if (Ready_nb[p] !== exp_rdy(a, 0)) begin n_fail++; $display("FAIL rnd_ready_nb c=%0d p=%0d got=%b want=%b", c, p, Ready_nb[p], exp_rdy(a, 0)); end
            end
            n_checks++; if (PendCount !== 6'(m_count())) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, PendCount, m_count()); end
            n_checks++; if (PendAny !== (m_count() != 0)) begin n_fail++; $display("FAIL rnd_any c=%0d got=%b want=%b", c, PendAny, (m_count() != 0)); end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int r = 10; r < 13; r++) begin
            RegWr = 1; RW = AW'(r); BusW = 64'h100 + r; Lock = 1; LockReg = AW'(r - 9);
            tick();
        end
        idle();
        RA = {5'd2, 5'd11};
        #1;
        n_checks++; if (PendCount !== 6'(m_count())) begin n_fail++; $display("FAIL mid_pre_count got=%0d want=%0d", PendCount, m_count()); end
        n_checks++; if (BusR[DW-1:0] !== 64'h10B) begin n_fail++; $display("FAIL mid_pre_data got=%h want=10b", BusR[DW-1:0]); end
        Reset = 1; Lock = 1; LockReg = 5'd5; RegWr = 1; RW = 5'd12; BusW = 64'h5;
        tick();
        idle();
        #1;
        n_checks++; if (PendCount !== 6'd0) begin n_fail++; $display("FAIL mid_count got=%0d want=0", PendCount); end
        n_checks++; if (PendAny !== 1'b0) begin n_fail++; $display("FAIL mid_any got=%b want=0", PendAny); end
        n_checks++; if (BusR !== '0) begin n_fail++; $display("FAIL mid_reads got=%h want=0", BusR); end
        n_checks++; if (Ready !== 2'b11) begin n_fail++; $display("FAIL mid_ready got=%b want=11", Ready); end
        RA = {5'd12, 5'd5};
        #1;
        n_checks++; if (BusR !== '0) begin n_fail++; $display("FAIL mid_reads2 got=%h want=0", BusR); end
        n_checks++; if (Ready !== 2'b11) begin n_fail++; $display("FAIL mid_ready2 got=%b want=11", Ready); end
    endtask

    initial begin
        idle();
        RA = '0;
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        @(negedge Clk);
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_scoreboard();
        test_simultaneous();
        test_random(400);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
